mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (IF) and the load/store requester (DATA).
- Sits between the core's fetch and data-access paths and the memory model.
- Allows one outstanding transaction at a time; DATA has priority, with a starvation guard for IF.
- Routes each response back to its owner and supports dropping an in-flight fetch on redirect.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width (the IF response returns 32 bits).
- STARVE_LIMIT, 4, maximum consecutive DATA grants while IF is pending; the next grant is forced to IF.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address, 4-byte aligned.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_flush  in  1  discard the in-flight fetch response (redirect).
- if_rsp_valid  out  1  fetch response pulse.
- if_rsp_inst  out  32  fetched instruction.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  data address.
- d_req_wdata  in  DATA_W  store data.
- d_req_wmask  in  DATA_W/8  byte mask.
- d_req_ready  out  1  data request accepted.
- d_rsp_valid  out  1  data response pulse (loads and stores).
- d_rsp_rdata  out  DATA_W  load data.
- mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/1/ADDR_W/DATA_W/DATA_W/8  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  memory response, one cycle wide.
- mem_rsp_rdata  in  DATA_W  response data.
- stray_rsp  out  1  sticky flag: a response arrived with no owner.

Behaviour:
- States: IDLE, IF_WAIT, D_WAIT.
- Reset (rstn low, async): state IDLE; streak counter 0; drop flag 0; latched addr[2] 0; stray_rsp 0.
  - All valid/ready outputs are 0; data outputs are 0.
  - A transaction in flight at reset is abandoned.
- IDLE, grant computation (combinational):
  - If d_req_valid and not (if_req_valid and streak == STARVE_LIMIT): grant DATA.
  - Else if if_req_valid: grant IF.
  - Else: no grant.
- IDLE, request drive: mem_req_* is muxed from the granted requester, with mem_req_valid = 1.
  - For IF: we = 0, wmask = 0, wdata = 0.
  - The granted requester's ready = mem_req_ready; the other requester's ready = 0.
- Handshake (mem_req_valid and mem_req_ready): next state D_WAIT or IF_WAIT.
  - IF grant: latch if_req_addr[2].
- Streak counter:
  - Increments on a DATA handshake while if_req_valid is 1, saturating at STARVE_LIMIT.
  - Clears on an IF handshake, or on any cycle where if_req_valid is 0.
- While a grant is not accepted (mem_req_ready = 0): the request stays combinational; requesters must hold valid and payload stable until ready.
- WAIT states:
  - mem_req_valid = 0; both readies are 0.
  - On mem_rsp_valid: pulse the owner's rsp_valid for that same cycle (combinational passthrough), then next state IDLE.
  - Throughput is at most one transaction per 2 cycles; a response with 0 wait gives 1-cycle latency from handshake to rsp.
- IF response selection: if_rsp_inst = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - d_rsp_rdata = mem_rsp_rdata.
  - rsp data outputs are 0 when their valid is 0.
- Flush:
  - if_flush in IF_WAIT sets the drop flag. The matching response is consumed (return to IDLE) with if_rsp_valid = 0. The drop flag clears on exit.
  - if_flush in the same cycle as mem_rsp_valid in IF_WAIT: the response is dropped.
  - if_flush in IDLE or D_WAIT: no effect.
- mem_rsp_valid in IDLE: ignored and stray_rsp set; stray_rsp clears only on reset.
- Simultaneous valid requests with streak < STARVE_LIMIT: DATA wins.

Decomposition:
- CorePack additions:
  - mem_arb_state_enum {ARB_IDLE, ARB_IF_WAIT, ARB_D_WAIT}.
  - mem_owner_enum {OWN_NONE, OWN_IF, OWN_DATA}.
- Sub-module mem_arb_grant: combinational grant logic plus the registered streak counter.
  - Inputs: clk, rstn, if_req_valid, d_req_valid, handshake, owner.
  - Output: grant.
- The top level holds the FSM, the request mux, the response routing, and the flush/stray logic.

Test Plan:
1. Lone fetch:
   - Stimulus: if_req addr=0x1004, mem_req_ready=1; the response arrives 1 cycle later with rdata=0x00A00093_00000013.
   - Required: if_rsp_valid for 1 cycle with if_rsp_inst=0x00A00093; d_rsp_valid stays 0.
2. Contention:
   - Stimulus: IF and DATA load (addr 0x2000) are valid in the same cycle, streak=0.
   - Required: DATA is granted first and d_rsp_rdata equals memory data; IF is granted in the next IDLE.
3. Starvation:
   - Stimulus: d_req_valid and if_req_valid held high, each transaction answered in 1 cycle.
   - Required: grant order D,D,D,D,IF,D; the streak counter returns to 0 after the IF grant.
4. Flush:
   - Stimulus: if_flush asserted in IF_WAIT, response 3 cycles later.
   - Required: no if_rsp_valid; state returns to IDLE; the next fetch proceeds normally.
5. Backpressure:
   - Stimulus: store with wmask=0x0F and mem_req_ready=0 for 4 cycles.
   - Required: mem_req_* stays stable and d_req_ready=0 for those cycles; handshake on cycle 5; d_rsp_valid is set on the ack.
6. Stray response and reset:
   - Stimulus: mem_rsp_valid in IDLE, then rstn low mid-D_WAIT.
   - Required: stray_rsp=1 after the stray response; after reset stray_rsp=0, state IDLE, and all valids are 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory-port arbiter: FSM state codes,
//   transaction owner encoding and the fetch-word select helper.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // FSM state codes (plain constants so legacy code can share them).
    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_IF_WAIT = 2'd1;
    localparam logic [1:0] ARB_D_WAIT  = 2'd2;

    // Which requester a grant / in-flight transaction belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } mem_owner_e;

    // A fetch returns one 32-bit instruction out of the 64-bit memory beat;
    // address bit 2 picks the half.
    function automatic logic [31:0] select_word(input logic hi, input logic [63:0] rdata);
        return hi ? rdata[63:32] : rdata[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
//   Combinational grant decision (DATA first, IF forced after STARVE_LIMIT
//   consecutive DATA grants while IF waits) plus the registered streak counter.
//   Ports:
//     clk, rstn       clock / async active-low reset
//     if_req_valid    fetch requester is asking
//     d_req_valid     data requester is asking
//     handshake       a request was accepted by memory this cycle
//     owner           owner of the accepted request (valid with handshake)
//     grant           requester that would be granted this cycle
// -----------------------------------------------------------------------------
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       if_req_valid,
    input  logic       d_req_valid,
    input  logic       handshake,
    input  logic [1:0] owner,
    output logic [1:0] grant
);

    localparam int                  STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] LIMIT    = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_starved;

    assign if_starved = if_req_valid && (streak_q == LIMIT);

    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = OWN_NONE;
        if (d_req_valid && !if_starved) begin
            grant = OWN_DATA;
        end else if (if_req_valid) begin
            grant = OWN_IF;
        end
    end

    // The streak only measures DATA wins while IF is actually waiting, so it
    // resets whenever IF stops asking.
    always_comb begin
        streak_d = streak_q;
        if (!if_req_valid) begin
            streak_d = '0;
        end else if (handshake && owner == OWN_IF) begin
            streak_d = '0;
        end else if (handshake && owner == OWN_DATA && streak_q != LIMIT) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and load/store
//   (DATA). One transaction outstanding at a time; responses are routed back
//   to the owner, fetch responses can be dropped on redirect, and responses
//   with no owner raise a sticky stray_rsp flag.
//   Ports:
//     clk, rstn                    clock / async active-low reset
//     if_req_* / if_rsp_*          fetch request / 32-bit instruction response
//     if_flush                     drop the in-flight fetch response
//     d_req_* / d_rsp_*            load/store request / response
//     mem_req_* / mem_rsp_*        unified memory port
//     stray_rsp                    sticky: response arrived while idle
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [31:0]         if_rsp_inst,

    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,

    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,

    output logic                stray_rsp
);

    logic [1:0] state_q, state_d;
    logic       drop_q, drop_d;     // in-flight fetch was flushed
    logic       hi_q, hi_d;         // latched fetch address bit 2
    logic       stray_q, stray_d;
    logic [1:0] grant;
    logic       handshake;

    assign handshake = (state_q == ARB_IDLE) && (grant != OWN_NONE) && mem_req_ready;
    assign stray_rsp = stray_q;

    mem_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .rstn         (rstn),
        .if_req_valid (if_req_valid),
        .d_req_valid  (d_req_valid),
        .handshake    (handshake),
        .owner        (grant),
        .grant        (grant)
    );

    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        hi_d          = hi_q;
        stray_d       = stray_q;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        if_rsp_valid  = 1'b0;
        if_rsp_inst   = '0;
        d_rsp_valid   = 1'b0;
        d_rsp_rdata   = '0;

        // Outputs are held quiet for the whole reset, not just after it.
        if (rstn) begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant == OWN_DATA) begin
                        mem_req_valid = 1'b1;
                        mem_req_we    = d_req_we;
                        mem_req_addr  = d_req_addr;
                        mem_req_wdata = d_req_wdata;
                        mem_req_wmask = d_req_wmask;
                        d_req_ready   = mem_req_ready;
                    end else if (grant == OWN_IF) begin
                        mem_req_valid = 1'b1;
                        mem_req_addr  = if_req_addr;
                        if_req_ready  = mem_req_ready;
                    end
                    if (handshake) begin
                        if (grant == OWN_IF) begin
                            state_d = ARB_IF_WAIT;
                            hi_d    = if_req_addr[2];
                        end else begin
                            state_d = ARB_D_WAIT;
                        end
                    end
                    if (mem_rsp_valid) begin
                        stray_d = 1'b1;
                    end
                end
                ARB_IF_WAIT: begin
                    if (mem_rsp_valid) begin
                        // A flush in the response cycle drops it too.
                        if (!drop_q && !if_flush) begin
                            if_rsp_valid = 1'b1;
                            if_rsp_inst  = select_word(hi_q, 64'(mem_rsp_rdata));
                        end
                        state_d = ARB_IDLE;
                        drop_d  = 1'b0;
                    end else if (if_flush) begin
                        drop_d = 1'b1;
                    end
                end
                ARB_D_WAIT: begin
                    if (mem_rsp_valid) begin
                        d_rsp_valid = 1'b1;
                        d_rsp_rdata = mem_rsp_rdata;
                        state_d     = ARB_IDLE;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                end
            endcase
        end
    end

    // NOTE: only control state is reset; a transaction in flight at reset is
    // simply abandoned because the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            drop_q  <= 1'b0;
            hi_q    <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            hi_q    <= hi_d;
            stray_q <= stray_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Table-driven vectors, directed multi-cycle sequences and a randomized run,
//   all checked every cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic        d_req_valid;
    logic        d_req_we;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [7:0]  d_req_wmask;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [63:0] d_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        stray_rsp;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_flush      (if_flush),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_inst   (if_rsp_inst),
        .d_req_valid   (d_req_valid),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_wmask   (d_req_wmask),
        .d_req_ready   (d_req_ready),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_rdata   (d_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .stray_rsp     (stray_rsp)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // busy: 0 = nothing outstanding, 1 = fetch outstanding, 2 = data outstanding
    int          m_busy;
    int          m_streak;      // DATA wins in a row while IF waits
    bit          m_drop;
    bit          m_hi;
    bit          m_stray;
    int          m_grant;
    bit          m_if_hs, m_d_hs, m_hs;

    logic        e_mreq_v, e_we, e_if_rdy, e_d_rdy, e_if_rsp_v, e_d_rsp_v;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [7:0]  e_wmask;
    logic [31:0] e_inst;

    task automatic model_reset();
        m_busy = 0; m_streak = 0; m_drop = 0; m_hi = 0; m_stray = 0;
        m_if_hs = 0; m_d_hs = 0; m_hs = 0;
    endtask

    task automatic model_comb();
        e_mreq_v = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_wmask = 0;
        e_if_rdy = 0; e_d_rdy = 0; e_if_rsp_v = 0; e_inst = 0;
        e_d_rsp_v = 0; e_rdata = 0; m_grant = 0;
        if (rstn) begin
            if (m_busy == 0) begin
                if (d_req_valid && !(if_req_valid && m_streak >= LIMIT)) m_grant = 2;
                else if (if_req_valid) m_grant = 1;
                if (m_grant == 2) begin
                    e_mreq_v = 1; e_we = d_req_we; e_addr = d_req_addr;
                    e_wdata = d_req_wdata; e_wmask = d_req_wmask; e_d_rdy = mem_req_ready;
                end else if (m_grant == 1) begin
                    e_mreq_v = 1; e_addr = if_req_addr; e_if_rdy = mem_req_ready;
                end
            end else if (m_busy == 1) begin
                if (mem_rsp_valid && !m_drop && !if_flush) begin
                    e_if_rsp_v = 1;
                    e_inst = m_hi ? mem_rsp_rdata[63:32] : mem_rsp_rdata[31:0];
                end
            end else if (mem_rsp_valid) begin
                e_d_rsp_v = 1;
                e_rdata = mem_rsp_rdata;
            end
        end
    endtask

    task automatic model_seq();
        model_comb();
        if (!rstn) begin
            model_reset();
        end else begin
            m_hs    = e_mreq_v && mem_req_ready;
            m_if_hs = m_hs && m_grant == 1;
            m_d_hs  = m_hs && m_grant == 2;
            if (!if_req_valid) m_streak = 0;
            else if (m_d_hs) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
            else if (m_if_hs) m_streak = 0;
            case (m_busy)
                0: begin
                    if (m_hs) m_busy = m_grant;
                    if (m_if_hs) m_hi = if_req_addr[2];
                    if (mem_rsp_valid) m_stray = 1;
                end
                1: begin
                    if (mem_rsp_valid) begin m_busy = 0; m_drop = 0; end
                    else if (if_flush) m_drop = 1;
                end
                default: if (mem_rsp_valid) m_busy = 0;
            endcase
        end
    endtask

    // Sample at the falling edge and compare every output with the model.
    task automatic sample();
        #4;
        if (!rstn) model_reset();
        model_comb();
        check("mem_req_valid", mem_req_valid, e_mreq_v);
        check("mem_req_we",    mem_req_we,    e_we);
        check("mem_req_addr",  mem_req_addr,  e_addr);
        check("mem_req_wdata", mem_req_wdata, e_wdata);
        check("mem_req_wmask", mem_req_wmask, e_wmask);
        check("if_req_ready",  if_req_ready,  e_if_rdy);
        check("d_req_ready",   d_req_ready,   e_d_rdy);
        check("if_rsp_valid",  if_rsp_valid,  e_if_rsp_v);
        check("if_rsp_inst",   if_rsp_inst,   e_inst);
        check("d_rsp_valid",   d_rsp_valid,   e_d_rsp_v);
        check("d_rsp_rdata",   d_rsp_rdata,   e_rdata);
        check("stray_rsp",     stray_rsp,     m_stray);
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = 0; if_flush = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wmask = 0;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        if_v;
        logic [63:0] if_addr;
        logic        flush;
        logic        d_v;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_wmask;
        logic        mem_rdy;
        logic        rsp_v;
        logic [63:0] rsp_data;
        logic        x_mreq_v;
        logic [63:0] x_maddr;
        logic        x_if_rdy;
        logic        x_d_rdy;
        logic        x_if_rsp_v;
        logic [31:0] x_inst;
        logic        x_d_rsp_v;
        logic [63:0] x_rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  grants;
        int          ng;
        bit          hs, is_if;
        int          rsp_delay;

        rstn = 0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        step();
        step();
        rstn = 1;
        step();

        // Lone fetch, contention, then a backpressured store.
        vecs.push_back('{1, 64'h1004, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 0, 64'h0,
                         1, 64'h1004, 1, 0, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 1, 64'h00A00093_00000013,
                         0, 64'h0, 0, 0, 1, 32'h00A00093, 0, 64'h0});
        vecs.push_back('{0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 0, 64'h0,
                         0, 64'h0, 0, 0, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h1008, 0, 1, 0, 64'h2000, 64'h0, 8'h00, 1, 0, 64'h0,
                         1, 64'h2000, 0, 1, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{1, 64'h1008, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 1, 64'h11112222_33334444,
                         0, 64'h0, 0, 0, 0, 32'h0, 1, 64'h11112222_33334444});
        vecs.push_back('{1, 64'h1008, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 0, 64'h0,
                         1, 64'h1008, 1, 0, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 1, 64'hDEADBEEF_CAFEF00D,
                         0, 64'h0, 0, 0, 1, 32'hCAFEF00D, 0, 64'h0});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{0, 64'h0, 0, 1, 1, 64'h3000, 64'h5555AAAA_5555AAAA, 8'h0F, 0, 0, 64'h0,
                             1, 64'h3000, 0, 0, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{0, 64'h0, 0, 1, 1, 64'h3000, 64'h5555AAAA_5555AAAA, 8'h0F, 1, 0, 64'h0,
                         1, 64'h3000, 0, 1, 0, 32'h0, 0, 64'h0});
        vecs.push_back('{0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 1, 1, 64'h0,
                         0, 64'h0, 0, 0, 0, 32'h0, 1, 64'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            if_req_valid  = vecs[i].if_v;   if_req_addr = vecs[i].if_addr;
            if_flush      = vecs[i].flush;
            d_req_valid   = vecs[i].d_v;    d_req_we    = vecs[i].d_we;
            d_req_addr    = vecs[i].d_addr; d_req_wdata = vecs[i].d_wdata;
            d_req_wmask   = vecs[i].d_wmask;
            mem_req_ready = vecs[i].mem_rdy;
            mem_rsp_valid = vecs[i].rsp_v;  mem_rsp_rdata = vecs[i].rsp_data;
            sample();
            check($sformatf("vec%0d mem_req_valid", i), mem_req_valid, vecs[i].x_mreq_v);
            check($sformatf("vec%0d mem_req_addr", i),  mem_req_addr,  vecs[i].x_maddr);
            check($sformatf("vec%0d if_req_ready", i),  if_req_ready,  vecs[i].x_if_rdy);
            check($sformatf("vec%0d d_req_ready", i),   d_req_ready,   vecs[i].x_d_rdy);
            check($sformatf("vec%0d if_rsp_valid", i),  if_rsp_valid,  vecs[i].x_if_rsp_v);
            check($sformatf("vec%0d if_rsp_inst", i),   if_rsp_inst,   vecs[i].x_inst);
            check($sformatf("vec%0d d_rsp_valid", i),   d_rsp_valid,   vecs[i].x_d_rsp_v);
            check($sformatf("vec%0d d_rsp_rdata", i),   d_rsp_rdata,   vecs[i].x_rdata);
            advance();
        end
        idle_inputs();
        step();

        // Starvation guard: both requesters held, every transaction answered
        // one cycle later. Expected grant order D,D,D,D,IF,D (bit set = IF).
        if_req_valid = 1; if_req_addr = 64'h4000;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h6000;
        mem_rsp_rdata = 64'h0BADF00D_00C0FFEE;
        grants = '0; ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            sample();
            hs = mem_req_valid && mem_req_ready;
            is_if = if_req_ready;
            advance();
            if (hs) begin
                grants[ng] = is_if;
                ng++;
                mem_rsp_valid = 1;
                if (is_if) check("streak cleared after IF grant", dut.u_grant.streak_q, 0);
            end else begin
                mem_rsp_valid = 0;
            end
        end
        check("starvation grant count", ng, 6);
        check("starvation grant order", grants, 6'b010000);
        if_req_valid = 0; d_req_valid = 0;
        step();
        idle_inputs();
        step();

        // Flush in IF_WAIT, response three cycles later is swallowed.
        if_req_valid = 1; if_req_addr = 64'h5000;
        step();
        if_req_valid = 0; if_flush = 1;
        step();
        if_flush = 0;
        step();
        step();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'hFFFFFFFF_EEEEEEEE;
        sample();
        check("flushed fetch no if_rsp_valid", if_rsp_valid, 0);
        advance();
        mem_rsp_valid = 0;
        if_req_valid = 1; if_req_addr = 64'h5004;
        sample();
        check("post-flush fetch issued", mem_req_valid, 1);
        advance();
        if_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h12345678_9ABCDEF0;
        sample();
        check("post-flush if_rsp_valid", if_rsp_valid, 1);
        check("post-flush if_rsp_inst", if_rsp_inst, 32'h12345678);
        advance();
        mem_rsp_valid = 0;

        // Stray response in IDLE, then reset in the middle of D_WAIT.
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h1;
        step();
        mem_rsp_valid = 0;
        sample();
        check("stray_rsp set", stray_rsp, 1);
        advance();
        d_req_valid = 1; d_req_addr = 64'h7000;
        step();
        d_req_valid = 0;
        step();
        rstn = 0;
        d_req_valid = 1; if_req_valid = 1; if_req_addr = 64'h8000;
        sample();
        check("reset stray_rsp", stray_rsp, 0);
        check("reset mem_req_valid", mem_req_valid, 0);
        check("reset d_req_ready", d_req_ready, 0);
        advance();
        d_req_valid = 0; if_req_valid = 0;
        rstn = 1;
        step();
        if_req_valid = 1;
        sample();
        check("after reset IDLE grants fetch", mem_req_valid && if_req_ready, 1);
        advance();
        if_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_rdata = 64'hAAAA0000_BBBB1111;
        step();
        idle_inputs();
        step();

        // Randomized traffic against the model.
        rsp_delay = 0;
        for (int c = 0; c < 400; c++) begin
            if (if_req_valid && m_if_hs) if_req_valid = 0;
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1;
                if_req_addr = {32'h0, $urandom_range(0, 32'h0FFF_FFFF), 2'b00} & 64'hFFFF_FFFF_FFFF_FFFC;
            end
            if (d_req_valid && m_d_hs) d_req_valid = 0;
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1;
                d_req_we = 1'($urandom_range(0, 1));
                d_req_addr = {$urandom, $urandom};
                d_req_wdata = {$urandom, $urandom};
                d_req_wmask = 8'($urandom_range(0, 255));
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            if_flush = ($urandom_range(0, 5) == 0);
            mem_rsp_rdata = {$urandom, $urandom};
            if (m_busy != 0) begin
                if (m_hs) rsp_delay = $urandom_range(0, 3);
                if (rsp_delay == 0) begin
                    mem_rsp_valid = 1;
                end else begin
                    mem_rsp_valid = 0;
                    rsp_delay--;
                end
            end else begin
                mem_rsp_valid = ($urandom_range(0, 60) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
